load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory interface: accepts one load/store request at a time from the CPU datapath and runs a word-granular request/acknowledge transaction to a multi-cycle data memory. Generates byte enables and lane-replicated write data, and extracts and sign/zero-extends load data. Detects misaligned and illegal accesses before they reach the bus, and bounds every bus transaction with a timeout.

## Interface
- `TIMEOUT`, 16: maximum bus cycles waited for `mem_ack` (≥1).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_valid`  in  1  request present; sampled only when `cpu_ready`=1.
- `cpu_ready`  out  1  unit idle and able to accept; reset value 1.
- `cpu_wen`  in  1  1 = store, 0 = load.
- `cpu_rwtype`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  store data, right-justified.
- `cpu_sign_extend`  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- `cpu_done`  out  1  one-cycle completion pulse; reset 0.
- `cpu_err`  out  2  valid with `cpu_done`: 00 ok, 01 misaligned, 10 timeout, 11 illegal type; reset 0.
- `cpu_rdata`  out  32  formatted load data, valid with `cpu_done`; reset 0.
- `mem_req`  out  1  bus request; reset 0.
- `mem_we`  out  1  write strobe qualifier; reset 0.
- `mem_addr`  out  32  word-aligned address (`{addr[31:2],2'b00}`); reset 0.
- `mem_be`  out  4  byte enables; reset 0.
- `mem_wdata`  out  32  lane-replicated write data; reset 0.
- `mem_ack`  in  1  memory completion; `mem_rdata` valid in same cycle.
- `mem_rdata`  in  32  full read word.

## Operation
- States: IDLE, BUS, DONE. `cpu_ready` = (state == IDLE).
- IDLE: on `cpu_valid`, latch request. If `cpu_rwtype`=11 → DONE, err 11. If half with addr[0]=1, or word with addr[1:0]≠00 → DONE, err 01. Otherwise → BUS, driving registered `mem_*`. Erroring requests never assert `mem_req`.
- Byte enables: byte → `mem_be` = 1<<addr[1:0], `mem_wdata` = {4{wdata[7:0]}`; half → addr[1]=0: 0011, else 1100, `mem_wdata` = {2{wdata[15:0]}}; word → 1111, `mem_wdata` = wdata. Loads drive the same `mem_be`, and `mem_wdata` = 0.
- BUS: `mem_req` and all `mem_*` held stable until the handshake ends. `mem_ack`=1 → capture formatted data, drop `mem_req`, → DONE, err 00.
- Timeout counter: cleared on entry to BUS, increments each BUS cycle without ack. If no ack and counter == `TIMEOUT`-1 → drop `mem_req`, → DONE, err 10. Ack in that same cycle wins (err 00).
- Load formatting: select lane by addr[1:0] (byte) or addr[1] (half). Upper bits = `cpu_sign_extend` & lane MSB, else 0. Word passes through unchanged.
- `cpu_rdata` = 0 for stores and for any error.
- DONE: `cpu_done`=1 for exactly one cycle → IDLE.
- A late `mem_ack` arriving in IDLE or DONE is ignored.
- `rst` mid-transaction: all outputs and state return to reset values immediately (asynchronously), and the transaction is abandoned. `cpu_valid` is ignored while `rst`=1.

## Timing
- Request accepted at edge T → `mem_req` high from T+1.
- Ack sampled at edge T+1+k (k≥0) → `cpu_done` high for the cycle after that edge. Minimum load/store latency is 2 cycles from accept to `cpu_done`.
- Error paths: misaligned or illegal → `cpu_done` the cycle after accept. Timeout → `cpu_done` `TIMEOUT`+1 cycles after accept.
- `cpu_ready` is low from T+1 until the cycle after `cpu_done`. Back-to-back throughput is one request per 3 cycles at best.
- All outputs are registered except `cpu_ready`, which decodes from the state register.

## Structure
- Package `lsu_pkg`: rwtype constants (BYTE 00, HALF 01, WORD 10), error codes, state enum, and a byte-enable/replicate function.
- Sub-module `lsu_load_align`: combinational lane select plus sign/zero extension (inputs: rdata, addr[1:0], rwtype, sign_extend). It is reusable by the non-pipelined datapath.

## Test plan
- Store byte 0xA5 at 0x1002 → `mem_addr`=0x1000, `mem_be`=0100, `mem_wdata`=0xA5A5A5A5, `mem_we`=1; ack after 3 cycles → `cpu_done` with err 00 and `cpu_rdata`=0.
- Load half at 0x2002 with `mem_rdata`=0x8001_1234: sign_extend=1 → 0xFFFF8001; sign_extend=0 → 0x00008001; byte at 0x2000 → 0x00000034.
- Word at 0x3001 → `cpu_done` next cycle with err 01 and no `mem_req`; rwtype 11 → err 11 with no `mem_req`.
- `mem_ack` never asserted, TIMEOUT=16 → `mem_req` high 16 cycles, err 10; repeat with ack on the 16th cycle → err 00.
- Assert `rst` during BUS → `mem_req` drops with no clock edge, and `cpu_ready`=1 after release; a following word load 0x4000 completes normally.
- Hold `cpu_valid` continuously across several requests → one transaction per accept, with no request lost or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, constants and helpers for the load/store unit.
package lsu_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BE_W = XLEN / 8;

   // Access size encoding on cpu_rwtype
   localparam logic [1:0] RW_BYTE    = 2'b00;
   localparam logic [1:0] RW_HALF    = 2'b01;
   localparam logic [1:0] RW_WORD    = 2'b10;
   localparam logic [1:0] RW_ILLEGAL = 2'b11;

   // Completion status reported on cpu_err
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUS  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Byte enables plus lane-replicated write data for one bus beat
   typedef struct packed {
      logic [BE_W-1:0] be;
      logic [XLEN-1:0] wdata;
   } lane_t;

   // Byte enables from size/offset; write data replicated across lanes, zero for loads
   function automatic lane_t store_lanes(input logic [1:0]      rwtype,
                                         input logic [1:0]      addr_lo,
                                         input logic [XLEN-1:0] wdata,
                                         input logic            wen);
      lane_t l;
      l.be    = '0;
      l.wdata = '0;
      case (rwtype)
         RW_BYTE: begin
            l.be    = 4'b0001 << addr_lo;
            l.wdata = {4{wdata[7:0]}};
         end
         RW_HALF: begin
            l.be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            l.wdata = {2{wdata[15:0]}};
         end
         RW_WORD: begin
            l.be    = 4'b1111;
            l.wdata = wdata;
         end
         default: ;
      endcase
      if (!wen) begin
         l.wdata = '0;
      end
      return l;
   endfunction

   // Half needs addr[0]=0, word needs addr[1:0]=00; bytes are always aligned
   function automatic logic is_misaligned(input logic [1:0] rwtype,
                                          input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (rwtype)
         RW_HALF: mis = addr_lo[0];
         RW_WORD: mis = |addr_lo;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatting: lane select by address, then sign/zero extension.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      addr_lo_i,
   input  logic [1:0]      rwtype_i,
   input  logic            sign_extend_i,
   output logic [XLEN-1:0] load_data_c_o
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Pick the addressed lane and extend it to a full word
   always_comb begin
      lane_byte     = rdata_i[7:0];
      lane_half     = rdata_i[15:0];
      load_data_c_o = rdata_i;

      case (addr_lo_i)
         2'd1:    lane_byte = rdata_i[15:8];
         2'd2:    lane_byte = rdata_i[23:16];
         2'd3:    lane_byte = rdata_i[31:24];
         default: lane_byte = rdata_i[7:0];
      endcase

      if (addr_lo_i[1]) begin
         lane_half = rdata_i[31:16];
      end

      case (rwtype_i)
         RW_BYTE: load_data_c_o = {{24{sign_extend_i & lane_byte[7]}}, lane_byte};
         RW_HALF: load_data_c_o = {{16{sign_extend_i & lane_half[15]}}, lane_half};
         default: load_data_c_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one CPU load/store at a time over a req/ack bus with timeout.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cpu_valid,
   output logic            cpu_ready,
   input  logic            cpu_wen,
   input  logic [1:0]      cpu_rwtype,
   input  logic [XLEN-1:0] cpu_addr,
   input  logic [XLEN-1:0] cpu_wdata,
   input  logic            cpu_sign_extend,
   output logic            cpu_done,
   output logic [1:0]      cpu_err,
   output logic [XLEN-1:0] cpu_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [BE_W-1:0] mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic             wen_q, wen_d;
   logic [1:0]       rwtype_q, rwtype_d;
   logic [1:0]       addr_lo_q, addr_lo_d;
   logic             sext_q, sext_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
   logic [BE_W-1:0]  mem_be_q, mem_be_d;
   logic [XLEN-1:0]  mem_wdata_q, mem_wdata_d;
   logic             cpu_done_q, cpu_done_d;
   logic [1:0]       cpu_err_q, cpu_err_d;
   logic [XLEN-1:0]  cpu_rdata_q, cpu_rdata_d;

   lane_t            lanes_c;
   logic             misalign_c;
   logic [XLEN-1:0]  load_data_c;

   assign lanes_c    = store_lanes(cpu_rwtype, cpu_addr[1:0], cpu_wdata, cpu_wen);
   assign misalign_c = is_misaligned(cpu_rwtype, cpu_addr[1:0]);

   lsu_load_align u_align (
      .rdata_i       (mem_rdata),
      .addr_lo_i     (addr_lo_q),
      .rwtype_i      (rwtype_q),
      .sign_extend_i (sext_q),
      .load_data_c_o (load_data_c)
   );

   // Next-state and registered-output decode
   always_comb begin
      state_d     = state_q;
      wen_d       = wen_q;
      rwtype_d    = rwtype_q;
      addr_lo_d   = addr_lo_q;
      sext_d      = sext_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      cpu_done_d  = 1'b0;
      cpu_err_d   = cpu_err_q;
      cpu_rdata_d = cpu_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_valid) begin
               wen_d     = cpu_wen;
               rwtype_d  = cpu_rwtype;
               addr_lo_d = cpu_addr[1:0];
               sext_d    = cpu_sign_extend;
               cnt_d     = '0;
               if (cpu_rwtype == RW_ILLEGAL) begin
                  state_d     = ST_DONE;
                  cpu_done_d  = 1'b1;
                  cpu_err_d   = ERR_ILLEGAL;
                  cpu_rdata_d = '0;
               end else if (misalign_c) begin
                  state_d     = ST_DONE;
                  cpu_done_d  = 1'b1;
                  cpu_err_d   = ERR_MISALIGN;
                  cpu_rdata_d = '0;
               end else begin
                  state_d     = ST_BUS;
                  mem_req_d   = 1'b1;
                  mem_we_d    = cpu_wen;
                  mem_addr_d  = {cpu_addr[XLEN-1:2], 2'b00};
                  mem_be_d    = lanes_c.be;
                  mem_wdata_d = lanes_c.wdata;
               end
            end
         end
         ST_BUS: begin
            // An ack in the final allowed cycle still completes successfully
            if (mem_ack) begin
               state_d     = ST_DONE;
               mem_req_d   = 1'b0;
               cpu_done_d  = 1'b1;
               cpu_err_d   = ERR_OK;
               cpu_rdata_d = wen_q ? '0 : load_data_c;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = ST_DONE;
               mem_req_d   = 1'b0;
               cpu_done_d  = 1'b1;
               cpu_err_d   = ERR_TIMEOUT;
               cpu_rdata_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wen_q       <= 1'b0;
         rwtype_q    <= RW_BYTE;
         addr_lo_q   <= 2'b00;
         sext_q      <= 1'b0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         cpu_done_q  <= 1'b0;
         cpu_err_q   <= ERR_OK;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wen_q       <= wen_d;
         rwtype_q    <= rwtype_d;
         addr_lo_q   <= addr_lo_d;
         sext_q      <= sext_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_done_q  <= cpu_done_d;
         cpu_err_q   <= cpu_err_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign cpu_ready = (state_q == ST_IDLE);
   assign cpu_done  = cpu_done_q;
   assign cpu_err   = cpu_err_q;
   assign cpu_rdata = cpu_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a size/offset arithmetic model.
module tb_load_store_unit;

   localparam int TO   = 16;
   localparam int BB_N = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_valid;
   logic        cpu_ready;
   logic        cpu_wen;
   logic [1:0]  cpu_rwtype;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_sign_extend;
   logic        cpu_done;
   logic [1:0]  cpu_err;
   logic [31:0] cpu_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          ready;
      bit          hung;
      bit          stable;
      logic [1:0]  err;
      logic [31:0] rdata;
      int          lat;
      int          reqc;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
   } obs_t;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .cpu_valid       (cpu_valid),
      .cpu_ready       (cpu_ready),
      .cpu_wen         (cpu_wen),
      .cpu_rwtype      (cpu_rwtype),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_sign_extend (cpu_sign_extend),
      .cpu_done        (cpu_done),
      .cpu_err         (cpu_err),
      .cpu_rdata       (cpu_rdata),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr        (mem_addr),
      .mem_be          (mem_be),
      .mem_wdata       (mem_wdata),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int sz(input logic [1:0] rw);
      return 1 << rw;
   endfunction

   function automatic logic [1:0] m_err(input logic [1:0] rw, input logic [31:0] a, input int ack_k);
      if (rw == 2'd3) return 2'd3;
      if ((a % sz(rw)) != 0) return 2'd1;
      if (ack_k < 0 || ack_k >= TO) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] rw, input logic [31:0] a);
      int size = sz(rw);
      int off  = ((a % 4) / size) * size;
      return 4'(((1 << size) - 1) << off);
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] rw, input logic [31:0] d, input bit wen);
      logic [31:0] w;
      int size = sz(rw);
      w = '0;
      if (wen) begin
         for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(d >> (8 * (i % size)));
      end
      return w;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] word,
                                           input bit sext, input bit wen, input logic [1:0] err);
      logic [63:0] v;
      logic [63:0] mask;
      int size = sz(rw);
      int off  = ((a % 4) / size) * size;
      if (wen || err != 2'd0) return 32'd0;
      mask = (64'd1 << (8 * size)) - 64'd1;
      v    = ({32'd0, word} >> (8 * off)) & mask;
      if (sext && v[8*size-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic int m_lat(input logic [1:0] err, input int ack_k);
      if (err == 2'd1 || err == 2'd3) return 1;
      if (err == 2'd2) return TO + 1;
      return ack_k + 2;
   endfunction

   function automatic int m_reqc(input logic [1:0] err, input int ack_k);
      if (err == 2'd1 || err == 2'd3) return 0;
      if (err == 2'd2) return TO;
      return ack_k + 1;
   endfunction

   // ---------------- driver: one request, memory acks on bus cycle ack_k (<0: never) ----------------
   task automatic do_txn(input bit wen, input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit sext, input int ack_k, input logic [31:0] rword, output obs_t o);
      int bus_c;
      o = '{default: 0};
      o.stable = 1'b1;
      o.hung   = 1'b1;
      @(negedge clk);
      o.ready         = cpu_ready;
      cpu_valid       = 1'b1;
      cpu_wen         = wen;
      cpu_rwtype      = rw;
      cpu_addr        = addr;
      cpu_wdata       = wdata;
      cpu_sign_extend = sext;
      @(posedge clk);
      @(negedge clk);
      cpu_valid       = 1'b0;
      cpu_addr        = $urandom;
      cpu_wdata       = $urandom;
      cpu_rwtype      = 2'($urandom_range(0, 3));
      cpu_wen         = 1'($urandom_range(0, 1));
      cpu_sign_extend = 1'($urandom_range(0, 1));
      bus_c = 0;
      for (int cyc = 1; cyc <= 64; cyc++) begin
         if (cyc > 1) @(negedge clk);
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         if (cpu_done) begin
            o.lat   = cyc;
            o.err   = cpu_err;
            o.rdata = cpu_rdata;
            o.hung  = 1'b0;
            break;
         end
         if (mem_req) begin
            if (bus_c == 0) begin
               o.addr  = mem_addr;
               o.be    = mem_be;
               o.wdata = mem_wdata;
               o.we    = mem_we;
            end else if (mem_addr !== o.addr || mem_be !== o.be || mem_wdata !== o.wdata || mem_we !== o.we) begin
               o.stable = 1'b0;
            end
            if (bus_c == ack_k) begin
               mem_ack   = 1'b1;
               mem_rdata = rword;
            end
            bus_c++;
         end
      end
      o.reqc  = bus_c;
      mem_ack = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cpu_ready); end
      n_cmp++; if (cpu_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cpu_done); end
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
      n_cmp++;
      if ({mem_we, mem_addr, mem_be, mem_wdata, cpu_err, cpu_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got we=%b addr=%h be=%b wdata=%h err=%b rdata=%h want all zero",
                  mem_we, mem_addr, mem_be, mem_wdata, cpu_err, cpu_rdata);
      end
      rst = 1'b0;
   endtask

   task automatic test_store_byte();
      obs_t o;
      do_txn(1'b1, 2'd0, 32'h0000_1002, 32'h5A5A_C3A5, 1'b0, 3, 32'hDEAD_BEEF, o);
      n_cmp++; if (o.addr !== 32'h0000_1000) begin n_bad++; $display("FAIL sb_addr: got %h want 00001000", o.addr); end
      n_cmp++; if (o.be !== 4'b0100) begin n_bad++; $display("FAIL sb_be: got %b want 0100", o.be); end
      n_cmp++; if (o.wdata !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o.wdata); end
      n_cmp++; if (o.we !== 1'b1) begin n_bad++; $display("FAIL sb_we: got %b want 1", o.we); end
      n_cmp++; if (o.err !== 2'b00 || o.hung) begin n_bad++; $display("FAIL sb_err: got %b hung=%0d want 00", o.err, o.hung); end
      n_cmp++; if (o.rdata !== 32'h0) begin n_bad++; $display("FAIL sb_rdata: got %h want 0", o.rdata); end
      n_cmp++; if (o.lat !== 5) begin n_bad++; $display("FAIL sb_latency: got %0d want 5", o.lat); end
   endtask

   task automatic test_load_format();
      obs_t o;
      do_txn(1'b0, 2'd1, 32'h0000_2002, 32'hFFFF_FFFF, 1'b1, 0, 32'h8001_1234, o);
      n_cmp++; if (o.rdata !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh_sext: got %h want ffff8001", o.rdata); end
      n_cmp++; if (o.be !== 4'b1100 || o.wdata !== 32'h0 || o.we !== 1'b0) begin
         n_bad++; $display("FAIL lh_bus: got be=%b wdata=%h we=%b want be=1100 wdata=0 we=0", o.be, o.wdata, o.we); end
      n_cmp++; if (o.lat !== 2) begin n_bad++; $display("FAIL lh_latency: got %0d want 2", o.lat); end
      do_txn(1'b0, 2'd1, 32'h0000_2002, 32'h0, 1'b0, 1, 32'h8001_1234, o);
      n_cmp++; if (o.rdata !== 32'h0000_8001) begin n_bad++; $display("FAIL lh_zext: got %h want 00008001", o.rdata); end
      do_txn(1'b0, 2'd0, 32'h0000_2000, 32'h0, 1'b1, 2, 32'h8001_1234, o);
      n_cmp++; if (o.rdata !== 32'h0000_0034) begin n_bad++; $display("FAIL lb_byte0: got %h want 00000034", o.rdata); end
      n_cmp++; if (o.be !== 4'b0001) begin n_bad++; $display("FAIL lb_be: got %b want 0001", o.be); end
   endtask

   task automatic test_errors();
      obs_t o;
      do_txn(1'b0, 2'd2, 32'h0000_3001, 32'h0, 1'b0, 0, 32'h1234_5678, o);
      n_cmp++; if (o.err !== 2'b01) begin n_bad++; $display("FAIL mis_err: got %b want 01", o.err); end
      n_cmp++; if (o.lat !== 1) begin n_bad++; $display("FAIL mis_latency: got %0d want 1", o.lat); end
      n_cmp++; if (o.reqc !== 0) begin n_bad++; $display("FAIL mis_noreq: got %0d req cycles want 0", o.reqc); end
      n_cmp++; if (o.rdata !== 32'h0) begin n_bad++; $display("FAIL mis_rdata: got %h want 0", o.rdata); end
      do_txn(1'b1, 2'd3, 32'h0000_3000, 32'hFFFF_FFFF, 1'b0, 0, 32'h1234_5678, o);
      n_cmp++; if (o.err !== 2'b11) begin n_bad++; $display("FAIL ill_err: got %b want 11", o.err); end
      n_cmp++; if (o.reqc !== 0 || o.lat !== 1) begin n_bad++; $display("FAIL ill_noreq: got reqc=%0d lat=%0d want 0/1", o.reqc, o.lat); end
   endtask

   task automatic test_timeout();
      obs_t o;
      do_txn(1'b0, 2'd2, 32'h0000_6000, 32'h0, 1'b0, -1, 32'h0, o);
      n_cmp++; if (o.err !== 2'b10 || o.hung) begin n_bad++; $display("FAIL to_err: got %b hung=%0d want 10", o.err, o.hung); end
      n_cmp++; if (o.reqc !== TO) begin n_bad++; $display("FAIL to_reqc: got %0d want %0d", o.reqc, TO); end
      n_cmp++; if (o.lat !== TO + 1) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", o.lat, TO + 1); end
      n_cmp++; if (o.rdata !== 32'h0) begin n_bad++; $display("FAIL to_rdata: got %h want 0", o.rdata); end
      do_txn(1'b0, 2'd2, 32'h0000_6004, 32'h0, 1'b0, TO - 1, 32'hCAFE_F00D, o);
      n_cmp++; if (o.err !== 2'b00) begin n_bad++; $display("FAIL to_lastack_err: got %b want 00", o.err); end
      n_cmp++; if (o.rdata !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL to_lastack_rdata: got %h want cafef00d", o.rdata); end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      @(negedge clk);
      cpu_valid  = 1'b1;
      cpu_wen    = 1'b0;
      cpu_rwtype = 2'd2;
      cpu_addr   = 32'h0000_5000;
      @(posedge clk);
      @(negedge clk);
      cpu_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_busy: got req=%b want 1", mem_req); end
      #2 rst = 1'b1;
      cpu_valid = 1'b1;
      #1;
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_async_drop: got req=%b want 0", mem_req); end
      @(negedge clk);
      cpu_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (cpu_ready !== 1'b1 || mem_req !== 1'b0 || cpu_done !== 1'b0) begin
         n_bad++; $display("FAIL rmid_release: got ready=%b req=%b done=%b want 1/0/0", cpu_ready, mem_req, cpu_done); end
      do_txn(1'b0, 2'd2, 32'h0000_4000, 32'h0, 1'b0, 1, 32'h0BAD_C0DE, o);
      n_cmp++; if (o.err !== 2'b00 || o.rdata !== 32'h0BAD_C0DE || o.addr !== 32'h0000_4000) begin
         n_bad++; $display("FAIL rmid_after: got err=%b rdata=%h addr=%h want 00/0badc0de/00004000", o.err, o.rdata, o.addr); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  rw [BB_N];
      logic [31:0] ad [BB_N];
      logic [31:0] wd [BB_N];
      logic [31:0] wv [BB_N];
      bit          wn [BB_N];
      bit          sx [BB_N];
      logic [1:0]  e_err;
      logic [31:0] e_rd;
      int          exp_req, nreq, ndone, j;
      bit          prev_req;
      exp_req = 0; nreq = 0; ndone = 0; j = 0; prev_req = 1'b0;
      for (int k = 0; k < BB_N; k++) begin
         rw[k] = 2'($urandom_range(0, 2));
         ad[k] = $urandom;
         if (k == 3) begin
            rw[k] = 2'd2;
            ad[k] = ad[k] | 32'd1;
         end else begin
            ad[k] = ad[k] & ~32'(sz(rw[k]) - 1);
         end
         wd[k] = $urandom;
         wv[k] = $urandom;
         wn[k] = 1'($urandom_range(0, 1));
         sx[k] = 1'($urandom_range(0, 1));
         if (m_err(rw[k], ad[k], 0) == 2'd0) exp_req++;
      end
      @(negedge clk);
      cpu_wen = wn[0]; cpu_rwtype = rw[0]; cpu_addr = ad[0]; cpu_wdata = wd[0]; cpu_sign_extend = sx[0];
      cpu_valid = 1'b1;
      for (int cyc = 0; cyc < 20 * BB_N && ndone < BB_N; cyc++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req && !prev_req && j < BB_N) begin
            nreq++;
            n_cmp++;
            if (mem_addr !== {ad[j][31:2], 2'b00}) begin
               n_bad++; $display("FAIL b2b_addr[%0d]: got %h want %h", j, mem_addr, {ad[j][31:2], 2'b00});
            end
         end
         prev_req = mem_req;
         if (mem_req && j < BB_N) begin
            mem_ack   = 1'b1;
            mem_rdata = wv[j];
         end
         if (cpu_done && j < BB_N) begin
            e_err = m_err(rw[j], ad[j], 0);
            e_rd  = m_rdata(rw[j], ad[j], wv[j], sx[j], wn[j], e_err);
            n_cmp++;
            if (cpu_err !== e_err || cpu_rdata !== e_rd) begin
               n_bad++; $display("FAIL b2b_result[%0d]: got err=%b rdata=%h want err=%b rdata=%h", j, cpu_err, cpu_rdata, e_err, e_rd);
            end
            ndone++;
            j++;
            if (j < BB_N) begin
               cpu_wen = wn[j]; cpu_rwtype = rw[j]; cpu_addr = ad[j]; cpu_wdata = wd[j]; cpu_sign_extend = sx[j];
            end else begin
               cpu_valid = 1'b0;
            end
         end
      end
      cpu_valid = 1'b0;
      mem_ack   = 1'b0;
      n_cmp++; if (ndone !== BB_N) begin n_bad++; $display("FAIL b2b_done_count: got %0d want %0d", ndone, BB_N); end
      n_cmp++; if (nreq !== exp_req) begin n_bad++; $display("FAIL b2b_req_count: got %0d want %0d", nreq, exp_req); end
   endtask

   task automatic test_random();
      obs_t        o;
      logic [1:0]  rw, e_err;
      logic [31:0] a, d, w, e_rd;
      bit          wen, sext;
      int          ack_k, r, p;
      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 9);
         rw = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a  = $urandom;
         if ($urandom_range(0, 2) != 0) a = a & ~32'(sz(rw) - 1);
         d    = $urandom;
         w    = $urandom;
         wen  = 1'($urandom_range(0, 1));
         sext = 1'($urandom_range(0, 1));
         p    = $urandom_range(0, 9);
         ack_k = (p == 0) ? -1 : (p == 1) ? TO - 1 : $urandom_range(0, 4);
         do_txn(wen, rw, a, d, sext, ack_k, w, o);
         e_err = m_err(rw, a, ack_k);
         e_rd  = m_rdata(rw, a, w, sext, wen, e_err);
         n_cmp++; if (o.ready !== 1'b1) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want 1", i, o.ready); end
         n_cmp++; if (o.hung) begin n_bad++; $display("FAIL rnd_no_done[%0d]: got no cpu_done want done", i); end
         n_cmp++; if (o.err !== e_err) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, o.err, e_err); end
         n_cmp++; if (o.rdata !== e_rd) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, o.rdata, e_rd); end
         n_cmp++; if (o.lat !== m_lat(e_err, ack_k)) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, o.lat, m_lat(e_err, ack_k)); end
         n_cmp++; if (o.reqc !== m_reqc(e_err, ack_k)) begin n_bad++; $display("FAIL rnd_reqc[%0d]: got %0d want %0d", i, o.reqc, m_reqc(e_err, ack_k)); end
         if (e_err == 2'd0 || e_err == 2'd2) begin
            n_cmp++;
            if (o.addr !== {a[31:2], 2'b00} || o.we !== wen) begin
               n_bad++; $display("FAIL rnd_addr_we[%0d]: got %h/%b want %h/%b", i, o.addr, o.we, {a[31:2], 2'b00}, wen);
            end
            n_cmp++; if (o.be !== m_be(rw, a)) begin n_bad++; $display("FAIL rnd_be[%0d]: got %b want %b", i, o.be, m_be(rw, a)); end
            n_cmp++; if (o.wdata !== m_wdata(rw, d, wen)) begin n_bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o.wdata, m_wdata(rw, d, wen)); end
            n_cmp++; if (o.stable !== 1'b1) begin n_bad++; $display("FAIL rnd_stable[%0d]: got %b want 1", i, o.stable); end
         end
      end
   endtask

   initial begin
      cpu_valid       = 1'b0;
      cpu_wen         = 1'b0;
      cpu_rwtype      = 2'd0;
      cpu_addr        = 32'h0;
      cpu_wdata       = 32'h0;
      cpu_sign_extend = 1'b0;
      mem_ack         = 1'b0;
      mem_rdata       = 32'h0;
      test_reset();
      test_store_byte();
      test_load_format();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
